// File: rtl/sync_decode.sv
// rtl/sync_decode.sv - video sync decoder: recovers pixel position, measures timing, tracks lock
`timescale 1ns/1ps
module sync_decode #(
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic        ACTIVE,
  output logic [12:0] H,
  output logic [12:0] V,
  output logic        DE_OUT,
  output logic [12:0] H_TOTAL,
  output logic [12:0] V_TOTAL,
  output logic [12:0] ACT_W,
  output logic [12:0] ACT_H,
  output logic        LOCKED,
  output logic        FRAME_START,
  output logic        ERR
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    CHECK  = 2'd2,
    LOCK   = 2'd3
  } state_t;

  localparam logic [12:0] CMAX   = 13'h1FFF;
  localparam logic [4:0]  LOCK_N = 5'(LOCK_FRAMES);

  function automatic logic [12:0] sat_inc(input logic [12:0] x);
    return (x == CMAX) ? x : x + 13'd1;
  endfunction

  logic        hs_q, vs_q, de_q;
  logic        hs_p, vs_p, de_p;
  logic [12:0] lc_q, lc_d;
  logic [12:0] line_len_q;
  logic [12:0] col_q;
  logic [12:0] row_q;
  logic [12:0] lines_q;
  logic [12:0] act_w_cand_q;
  state_t      state_q;
  logic [3:0]  cnt_q;

  logic        hs_rise, vs_rise, de_fall, timeout;
  logic [12:0] t_ht, t_vt, t_aw, t_ah;
  logic        t_match, len_bad;
  logic [4:0]  cnt_inc;

  assign hs_rise = hs_q & ~hs_p;
  assign vs_rise = vs_q & ~vs_p;
  assign de_fall = de_p & ~de_q;

  assign lc_d    = hs_rise ? 13'd0 : sat_inc(lc_q);
  assign timeout = (lc_q != CMAX) && (lc_d == CMAX);

  // The tuple sees same-cycle line end / active end so a coincident edge is not lost.
  assign t_ht    = hs_rise ? sat_inc(lc_q) : line_len_q;
  assign t_vt    = sat_inc(lines_q);
  assign t_aw    = de_fall ? col_q : act_w_cand_q;
  assign t_ah    = de_fall ? sat_inc(row_q) : row_q;
  assign t_match = (t_ht == H_TOTAL) && (t_vt == V_TOTAL) && (t_aw == ACT_W) && (t_ah == ACT_H);
  assign len_bad = hs_rise && (sat_inc(lc_q) != H_TOTAL);
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      hs_p         <= 1'b0;
      vs_p         <= 1'b0;
      de_p         <= 1'b0;
      lc_q         <= '0;
      line_len_q   <= '0;
      col_q        <= '0;
      row_q        <= '0;
      lines_q      <= '0;
      act_w_cand_q <= '0;
      H            <= '0;
      V            <= '0;
      DE_OUT       <= 1'b0;
      FRAME_START  <= 1'b0;
    end else begin
      hs_q <= (HSYNC == HS_POL);
      vs_q <= (VSYNC == VS_POL);
      de_q <= ACTIVE;
      hs_p <= hs_q;
      vs_p <= vs_q;
      de_p <= de_q;

      lc_q <= lc_d;
      if (hs_rise) line_len_q <= sat_inc(lc_q);
      col_q <= de_q ? sat_inc(col_q) : 13'd0;

      if (vs_rise)      row_q <= '0;
      else if (de_fall) row_q <= sat_inc(row_q);

      if (vs_rise)      lines_q <= '0;
      else if (hs_rise) lines_q <= sat_inc(lines_q);

      if (de_fall) act_w_cand_q <= col_q;

      H           <= de_q ? col_q : 13'd0;
      V           <= de_q ? row_q : 13'd0;
      DE_OUT      <= de_q;
      FRAME_START <= vs_rise;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      LOCKED  <= 1'b0;
      ERR     <= 1'b0;
      H_TOTAL <= '0;
      V_TOTAL <= '0;
      ACT_W   <= '0;
      ACT_H   <= '0;
    end else begin
      ERR <= 1'b0;
      if (timeout) begin
        state_q <= SEARCH;
        cnt_q   <= '0;
        LOCKED  <= 1'b0;
        ERR     <= 1'b1;
      end else begin
        case (state_q)
          SEARCH: if (vs_rise) state_q <= ARMED;
          ARMED: begin
            if (vs_rise) begin
              H_TOTAL <= t_ht;
              V_TOTAL <= t_vt;
              ACT_W   <= t_aw;
              ACT_H   <= t_ah;
              cnt_q   <= 4'd1;
              if (LOCK_N <= 5'd1) begin
                state_q <= LOCK;
                LOCKED  <= 1'b1;
              end else begin
                state_q <= CHECK;
              end
            end
          end
          CHECK: begin
            if (vs_rise) begin
              if (t_match) begin
                cnt_q <= cnt_inc[3:0];
                if (cnt_inc >= LOCK_N) begin
                  state_q <= LOCK;
                  LOCKED  <= 1'b1;
                end
              end else begin
                H_TOTAL <= t_ht;
                V_TOTAL <= t_vt;
                ACT_W   <= t_aw;
                ACT_H   <= t_ah;
                cnt_q   <= 4'd1;
              end
            end
          end
          LOCK: begin
            if (vs_rise && !t_match) begin
              H_TOTAL <= t_ht;
              V_TOTAL <= t_vt;
              ACT_W   <= t_aw;
              ACT_H   <= t_ah;
              cnt_q   <= 4'd1;
              LOCKED  <= 1'b0;
              ERR     <= 1'b1;
              state_q <= CHECK;
            end else if (len_bad) begin
              H_TOTAL <= t_ht;
              cnt_q   <= 4'd1;
              LOCKED  <= 1'b0;
              ERR     <= 1'b1;
              state_q <= CHECK;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: doc/sync_decode.md
SYNC_DECODE -- requirements
Module: sync_decode

Interface
REQ-001 SHALL have parameter HS_POL, default 0, HSYNC asserted level (0 = active-low).
REQ-002 SHALL have parameter VS_POL, default 0, VSYNC asserted level (0 = active-low).
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, number of consecutive identical frame measurements required to lock (range 1-15).
REQ-004 SHALL have port CLK, input, 1, pixel clock; all logic on its rising edge; one clock only.
REQ-005 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports HSYNC, VSYNC and ACTIVE, each input, 1, the incoming sync generator signals (ACTIVE = data enable).
REQ-007 SHALL have ports H and V, each output, 13, recovered active-area column and row of the current pixel.
REQ-008 SHALL have port DE_OUT, output, 1, ACTIVE delayed to align with H and V.
REQ-009 SHALL have ports H_TOTAL and V_TOTAL, each output, 13, measured clocks per line and lines per frame.
REQ-010 SHALL have ports ACT_W and ACT_H, each output, 13, measured active pixels per line and active lines per frame.
REQ-011 SHALL have port LOCKED, output, 1, timing stable.
REQ-012 SHALL have ports FRAME_START and ERR, each output, 1, single-cycle pulses.

Function
REQ-013 Inputs SHALL be registered once and normalised by HS_POL/VS_POL to hs_q, vs_q and de_q; edges SHALL be detected against the previous registered value.
REQ-014 hs_rise and vs_rise SHALL be the asserted-going edges; de_fall SHALL be the falling edge of de_q.
REQ-015 Line counter lc SHALL clear on hs_rise, else increment, saturating at 8191.
REQ-016 On hs_rise the line length SHALL be captured as lc+1.
REQ-017 Column counter SHALL clear when de_q is low and increment while de_q is high.
REQ-018 H SHALL equal the column counter value while de_q is high and 0 otherwise.
REQ-019 Active row counter SHALL increment on de_fall and clear on vs_rise; vs_rise SHALL win when both occur in the same cycle.
REQ-020 V SHALL equal the active row counter while de_q is high and 0 otherwise.
REQ-021 Line-in-frame counter SHALL increment on hs_rise and clear on vs_rise; vs_rise SHALL win over hs_rise.
REQ-022 Latency from input pins to H, V, DE_OUT and FRAME_START SHALL be exactly 2 CLK cycles.
REQ-023 FRAME_START SHALL pulse for 1 cycle per vs_rise.
REQ-024 On de_fall, the ACT_W candidate SHALL take the column count.
REQ-025 On vs_rise, the frame tuple {last line length, line count + 1, ACT_W candidate, active row count} SHALL be formed.
REQ-026 The lock FSM SHALL have states SEARCH, ARMED, CHECK and LOCK; it SHALL reset to SEARCH with match count 0.
REQ-027 SEARCH: the first vs_rise SHALL move to ARMED; the partial frame SHALL be discarded.
REQ-028 ARMED: the next vs_rise SHALL store the tuple to H_TOTAL/V_TOTAL/ACT_W/ACT_H, set count=1 and move to CHECK.
REQ-029 CHECK: on vs_rise with the tuple equal to the stored values, count SHALL increment; reaching LOCK_FRAMES SHALL move to LOCK and set LOCKED.
REQ-030 CHECK: on vs_rise with a mismatching tuple, the new tuple SHALL be stored and count set to 1.
REQ-031 With LOCK_FRAMES=1, the ARMED store SHALL go directly to LOCK.
REQ-032 LOCK: a vs_rise tuple mismatch, or any hs_rise line length not equal to H_TOTAL, SHALL pulse ERR, clear LOCKED, store the new values, set count=1 and move to CHECK.
REQ-033 Any state: lc reaching 8191 (no HSYNC) SHALL move to SEARCH, clear LOCKED and pulse ERR once; no further ERR SHALL occur until the next lock is lost.
REQ-034 H_TOTAL/V_TOTAL/ACT_W/ACT_H SHALL change only on vs_rise in ARMED/CHECK/LOCK, or on the REQ-032 unlock, and SHALL otherwise hold.
REQ-035 Widths: all counters SHALL be 13 bits with saturation; wrap SHALL never occur.

Reset
REQ-036 RST_N low SHALL asynchronously clear all counters, the edge history, H, V, DE_OUT, FRAME_START, ERR, LOCKED, H_TOTAL, V_TOTAL, ACT_W and ACT_H to 0, and set the FSM to SEARCH.
REQ-037 Reset deassertion mid-frame SHALL be treated as power-up: the first vs_rise SHALL be discarded.

Verification
REQ-038 XGA stream (1344x806 total, 1024x768 active, HS/VS active-low) from reset -> LOCKED rises on the 3rd vs_rise; H_TOTAL=1344, V_TOTAL=806, ACT_W=1024, ACT_H=768.
REQ-039 Locked XGA, check pixel alignment -> first active pixel shows DE_OUT=1, H=0, V=0 two cycles after ACTIVE rises; last pixel shows H=1023, V=767.
REQ-040 Locked, one line shortened to 1343 clocks -> ERR pulses 1 cycle, LOCKED falls, FSM in CHECK; relock after 2 clean frames.
REQ-041 Locked, HSYNC held deasserted 8191 clocks -> ERR pulses once, LOCKED=0, FSM SEARCH; relock on the 3rd vs_rise after HSYNC resumes.
REQ-042 HSYNC and VSYNC asserted in the same cycle -> line counter = 0 and row = 0 afterwards, no double count.
REQ-043 RST_N pulsed low mid-frame while locked -> all outputs 0 immediately (asynchronously); LOCKED returns only on the 3rd subsequent vs_rise.
